// File: rtl/psg_bus_master.sv
// Single-read system bus master behind the PSG eight-way arbiter; returns one sample per grant.
// Optional abort of stalled cycles after TMO_CYC clk: define PSG_BUSMST_TIMEOUT_EN.
module psg_bus_master #(
   parameter int AW      = 24,
   parameter int DW      = 16,
   parameter int TMO_CYC = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      req,
   input  logic [7:0]      sel,
   input  logic [2:0]      seln,
   input  logic [8*AW-1:0] ch_adr,
   output logic            arb_ack,
   output logic            m_cyc,
   output logic            m_stb,
   output logic            m_we,
   output logic [AW-1:0]   m_adr,
   input  logic            m_ack,
   input  logic [DW-1:0]   m_dat,
   output logic [DW-1:0]   ch_dat,
   output logic [7:0]      ch_done,
   output logic [7:0]      ch_err
);

   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

   state_t        state, state_nx;
   logic [2:0]    cur, cur_nx;
   logic [AW-1:0] adr_nx;
   logic          cyc_nx, arb_ack_nx;
   logic [DW-1:0] dat_nx;
   logic [7:0]    done_nx;
   logic          start;

`ifdef PSG_BUSMST_TIMEOUT_EN
   logic [7:0] wcnt, wcnt_nx;
   logic [7:0] err_nx;
   logic       tmo;
   // wcnt counts completed BUS clocks; the TMO_CYC-th BUS clock ends the cycle
   assign tmo = (wcnt == 8'(TMO_CYC - 1));
`endif

   assign start = (|sel) && req[seln];
   assign m_stb = m_cyc;
   assign m_we  = 1'b0;

   always_comb begin
      state_nx   = state;
      cur_nx     = cur;
      adr_nx     = m_adr;
      cyc_nx     = m_cyc;
      arb_ack_nx = arb_ack;
      dat_nx     = ch_dat;
      done_nx    = 8'd0;
`ifdef PSG_BUSMST_TIMEOUT_EN
      wcnt_nx    = wcnt;
      err_nx     = 8'd0;
`endif
      case (state)
         IDLE: begin
            arb_ack_nx = 1'b1;
`ifdef PSG_BUSMST_TIMEOUT_EN
            wcnt_nx    = 8'd0;
`endif
            if (start) begin
               cur_nx     = seln;
               adr_nx     = ch_adr[seln*AW +: AW];
               cyc_nx     = 1'b1;
               arb_ack_nx = 1'b0;
               state_nx   = BUS;
            end
         end
         BUS: begin
            if (m_ack) begin
               dat_nx   = m_dat;
               done_nx  = 8'd1 << cur;
               cyc_nx   = 1'b0;
               state_nx = DONE;
            end
`ifdef PSG_BUSMST_TIMEOUT_EN
            else if (tmo) begin
               err_nx   = 8'd1 << cur;
               cyc_nx   = 1'b0;
               state_nx = DONE;
            end
            wcnt_nx = wcnt + 8'd1;
`endif
         end
         DONE: begin
            // arb_ack held low one extra clk so the serviced channel can drop req
            arb_ack_nx = 1'b1;
            state_nx   = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cur     <= 3'd0;
         m_adr   <= '0;
         m_cyc   <= 1'b0;
         arb_ack <= 1'b1;
         ch_dat  <= '0;
         ch_done <= 8'd0;
      end else begin
         state   <= state_nx;
         cur     <= cur_nx;
         m_adr   <= adr_nx;
         m_cyc   <= cyc_nx;
         arb_ack <= arb_ack_nx;
         ch_dat  <= dat_nx;
         ch_done <= done_nx;
      end
   end

`ifdef PSG_BUSMST_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt   <= 8'd0;
         ch_err <= 8'd0;
      end else begin
         wcnt   <= wcnt_nx;
         ch_err <= err_nx;
      end
   end
`else
   assign ch_err = 8'd0;
`endif

endmodule

// File: tb/tb_psg_bus_master.sv
// Randomized scoreboard bench for psg_bus_master; build with PSG_BUSMST_TIMEOUT_EN to add the timeout case.
`timescale 1ns/1ps
module tb_psg_bus_master;
   localparam int AW = 24;
   localparam int DW = 16;
`ifdef PSG_BUSMST_TIMEOUT_EN
   localparam int TMO  = 4;
   localparam int MAXW = 3;
`else
   localparam int TMO  = 255;
   localparam int MAXW = 6;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [7:0]      req, sel;
   logic [2:0]      seln;
   logic [8*AW-1:0] ch_adr;
   logic            arb_ack, m_cyc, m_stb, m_we, m_ack;
   logic [AW-1:0]   m_adr;
   logic [DW-1:0]   m_dat, ch_dat;
   logic [7:0]      ch_done, ch_err;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int            ch;
      logic [DW-1:0] dat;
      bit            err;
   } exp_t;
   exp_t sb[$];

   psg_bus_master #(.AW(AW), .DW(DW), .TMO_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .req(req), .sel(sel), .seln(seln), .ch_adr(ch_adr),
      .arb_ack(arb_ack), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
      .m_ack(m_ack), .m_dat(m_dat), .ch_dat(ch_dat), .ch_done(ch_done), .ch_err(ch_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every response pulse must match the oldest outstanding request.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && (ch_done !== 8'd0 || ch_err !== 8'd0)) begin
            check("resp_onehot", 64'($countones(ch_done | ch_err)), 64'd1);
            if (sb.size() == 0) begin
               check("unexpected_resp", {ch_err, ch_done}, 64'd0);
            end else begin
               e = sb.pop_front();
               if (e.err) begin
                  check("err_vec", ch_err, 64'(8'd1 << e.ch));
                  check("err_no_done", ch_done, 64'd0);
               end else begin
                  check("done_vec", ch_done, 64'(8'd1 << e.ch));
                  check("done_dat", ch_dat, e.dat);
                  check("done_no_err", ch_err, 64'd0);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [8*AW-1:0] rnd_adrs();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Grant ch at an IDLE negedge, ack after 'waits' BUS clocks. nxt>=0 regrants to nxt right after
   // the start edge and keeps that grant held, so the following call services nxt.
   task automatic run_txn(input int ch, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                          input int waits, input int nxt, input logic [AW-1:0] nxt_adr);
      int oc;
      req = 8'($urandom);
      req[ch] = 1'b1;
      sel = 8'd1 << ch;
      seln = 3'(ch);
      ch_adr = rnd_adrs();
      ch_adr[ch*AW +: AW] = adr;
      sb.push_back('{ch, dat, 1'b0});
      @(negedge clk);
      check("start_cyc", m_cyc, 1);
      check("start_stb", m_stb, 1);
      check("start_adr", m_adr, adr);
      check("start_arb_ack", arb_ack, 0);
      if (nxt >= 0) begin
         req[nxt] = 1'b1;
         sel = 8'd1 << nxt;
         seln = 3'(nxt);
         ch_adr[nxt*AW +: AW] = nxt_adr;
      end else begin
         oc = $urandom_range(0, 7);
         sel = 8'd1 << oc;
         seln = 3'(oc);
         req = 8'hFF;
         ch_adr = rnd_adrs();
      end
      repeat (waits) begin
         @(negedge clk);
         check("wait_cyc", m_cyc, 1);
         check("wait_adr", m_adr, adr);
         check("wait_arb_ack", arb_ack, 0);
      end
      m_ack = 1'b1;
      m_dat = dat;
      @(negedge clk);
      m_ack = 1'($urandom_range(0, 1));
      m_dat = 16'($urandom);
      check("done_cyc", m_cyc, 0);
      check("done_arb_ack", arb_ack, 0);
      check("done_hold_dat", ch_dat, dat);
      if (nxt < 0) begin
         sel = 8'd0;
         req = 8'd0;
      end
      @(negedge clk);
      m_ack = 1'b0;
      check("idle_arb_ack", arb_ack, 1);
      check("idle_cyc", m_cyc, 0);
      check("idle_done", ch_done, 0);
   endtask

   initial begin
      int            pend;
      logic [AW-1:0] pend_adr;
      int            ch, nxt, n;
      logic [AW-1:0] adr, nadr;

      rst = 1'b1; req = 8'd0; sel = 8'd0; seln = 3'd0; ch_adr = '0; m_ack = 1'b0; m_dat = '0;
      repeat (2) @(negedge clk);
      check("rst_arb_ack", arb_ack, 1);
      check("rst_cyc", m_cyc, 0);
      check("rst_stb", m_stb, 0);
      check("rst_we", m_we, 0);
      check("rst_adr", m_adr, 0);
      check("rst_dat", ch_dat, 0);
      check("rst_done", ch_done, 0);
      check("rst_err", ch_err, 0);
      rst = 1'b0;

      // No grant at all, then grant to a channel whose req is low; m_ack in IDLE is ignored.
      repeat (2) @(negedge clk);
      check("nogrant_cyc", m_cyc, 0);
      sel = 8'h01; seln = 3'd0; req = 8'hFE; m_ack = 1'b1; m_dat = 16'h1234;
      repeat (3) begin
         @(negedge clk);
         check("noreq_cyc", m_cyc, 0);
         check("noreq_arb_ack", arb_ack, 1);
         check("noreq_done", ch_done, 0);
      end
      sel = 8'd0; req = 8'd0; m_ack = 1'b0;
      @(negedge clk);

      // Reset held 2 clk in the middle of a bus cycle.
      sel = 8'h08; seln = 3'd3; req = 8'h08; ch_adr = rnd_adrs();
      @(negedge clk);
      check("prerst_cyc", m_cyc, 1);
      sel = 8'd0; req = 8'd0;
      rst = 1'b1;
      @(negedge clk);
      check("midrst_cyc", m_cyc, 0);
      check("midrst_arb_ack", arb_ack, 1);
      check("midrst_done", ch_done, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("postrst_adr", m_adr, 0);
      check("postrst_dat", ch_dat, 0);
      check("postrst_done", ch_done, 0);

      // ch2 with 3 wait clocks; arbiter regrants to ch5 right after the start edge.
      run_txn(2, 24'h001230, 16'hBEEF, 3, 5, 24'h00ABCD);
      run_txn(5, 24'h00ABCD, 16'h5A5A, 0, -1, '0);
      // Back-to-back ch0 then ch7.
      run_txn(0, 24'h000010, 16'h0F0F, 1, 7, 24'hFFFFFE);
      run_txn(7, 24'hFFFFFE, 16'hF00D, 2, -1, '0);

`ifdef PSG_BUSMST_TIMEOUT_EN
      sel = 8'h08; seln = 3'd3; req = 8'h08; ch_adr = rnd_adrs();
      sb.push_back('{3, 16'h0, 1'b1});
      n = 0;
      @(negedge clk);
      sel = 8'd0; req = 8'd0;
      while (m_cyc === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("tmo_bus_clks", n, TMO);
      check("tmo_arb_ack", arb_ack, 0);
      @(negedge clk);
      check("tmo_idle_arb_ack", arb_ack, 1);
`endif

      pend = -1;
      pend_adr = '0;
      for (int t = 0; t < 40; t++) begin
         ch  = (pend >= 0) ? pend : $urandom_range(0, 7);
         adr = (pend >= 0) ? pend_adr : AW'($urandom);
         nxt = ($urandom_range(0, 2) == 0 && t < 39) ? $urandom_range(0, 7) : -1;
         nadr = AW'($urandom);
         run_txn(ch, adr, 16'($urandom), $urandom_range(0, MAXW), nxt, nadr);
         pend = nxt;
         pend_adr = nadr;
      end

      n = 0;
      while (sb.size() != 0 && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
